// File: rtl/seg7_scan_driver.sv
// Scans a NUM_DIGITS common-anode 7-seg display from a shadow copy of digits/blank flags; LEADING_ZERO_BLANK_EN suppresses leading zeros.
// Latency: seg_out/an_out/frame_done registered 1 clk after (index, shadow); no backpressure, load is sampled every cycle.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [4*NUM_DIGITS-1:0] shadow_dig;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [PRE_W-1:0]        presc;
  logic [IDX_W-1:0]        idx;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    seen_nz;
  logic                    presc_tc;
  logic [3:0]              cur_dig;
  logic                    cur_blank;
  logic [6:0]              seg_next;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; a blanked digit counts as zero. Digit 0 is always shown.
  always_comb begin
    lz_mask = '0;
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (!shadow_blank[i] && (shadow_dig[4*i +: 4] != 4'd0)) begin
        seen_nz = 1'b1;
      end
      lz_mask[i] = !seen_nz;
    end
  end
`else
  always_comb begin
    lz_mask = '0;
    seen_nz = 1'b0;
  end
`endif

  always_comb begin
    presc_tc  = (presc == PRE_LAST);
    cur_dig   = shadow_dig[4*idx +: 4];
    cur_blank = shadow_blank[idx] | lz_mask[idx];
    seg_next  = cur_blank ? 7'b1111111 : decode(cur_dig);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_dig   <= '0;
      shadow_blank <= '1;
      presc        <= '0;
      idx          <= '0;
      seg_out      <= 7'b1111111;
      an_out       <= '1;
      frame_done   <= 1'b0;
    end else begin
      if (load) begin
        shadow_dig   <= digits_in;
        shadow_blank <= blank_in;
      end
      if (presc_tc) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      seg_out    <= seg_next;
      an_out     <= ~(NUM_DIGITS'(1) << idx);
      frame_done <= presc_tc && (idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed table-driven bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .digits_in  (digits_in),
    .blank_in   (blank_in),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7f;
`else
  localparam logic [6:0] LZ = 7'h01;
`endif

  // Each row is held for n clocks; expected outputs are sampled after every one of those edges.
  typedef struct {
    logic        rn;
    logic        ld;
    logic [15:0] dig;
    logic [3:0]  blk;
    int          n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        fd;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  function automatic vec_t mk(input logic rn, input logic ld, input logic [15:0] dig,
                              input logic [3:0] blk, input int n, input logic [3:0] an,
                              input logic [6:0] seg, input logic fd);
    vec_t v;
    v.rn = rn; v.ld = ld; v.dig = dig; v.blk = blk;
    v.n = n; v.an = an; v.seg = seg; v.fd = fd;
    return v;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
  endtask

  initial begin
    // reset held 3 clocks
    tbl.push_back(mk(0, 0, 16'h0000, 4'h0, 3, 4'hf, 7'h7f, 0));
    // release + load 1234 on the first edge; outputs still reflect the blank shadow
    tbl.push_back(mk(1, 1, 16'h1234, 4'h0, 1, 4'he, 7'h7f, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 3, 4'he, 7'h4c, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'hd, 7'h06, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'hb, 7'h12, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 3, 4'h7, 7'h4f, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 1, 4'h7, 7'h4f, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 1, 4'he, 7'h4c, 0));
    // blank digit 2, anode still cycles
    tbl.push_back(mk(1, 1, 16'h1234, 4'h4, 1, 4'he, 7'h4c, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 2, 4'he, 7'h4c, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'hd, 7'h06, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'hb, 7'h7f, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 3, 4'h7, 7'h4f, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 1, 4'h7, 7'h4f, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 1, 4'he, 7'h4c, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 3, 4'he, 7'h4c, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'hd, 7'h06, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 3, 4'hb, 7'h7f, 0));
    // load 5678 on the 2->3 advance edge
    tbl.push_back(mk(1, 1, 16'h5678, 4'h0, 1, 4'hb, 7'h7f, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 3, 4'h7, 7'h24, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 1, 4'h7, 7'h24, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'he, 7'h00, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'hd, 7'h0f, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'hb, 7'h20, 0));
    // 0070: leading zeros depend on the build
    tbl.push_back(mk(1, 1, 16'h0070, 4'h0, 1, 4'h7, 7'h24, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 2, 4'h7, LZ,    0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 1, 4'h7, LZ,    1));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'he, 7'h01, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'hd, 7'h0f, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'hb, LZ,    0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 3, 4'h7, LZ,    0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 1, 4'h7, LZ,    1));
    // value sweep, load held high: each cycle shows the value captured one edge earlier
    tbl.push_back(mk(1, 1, 16'h0000, 4'h0, 1, 4'he, 7'h01, 0));
    tbl.push_back(mk(1, 1, 16'h1111, 4'h0, 1, 4'he, 7'h01, 0));
    tbl.push_back(mk(1, 1, 16'h2222, 4'h0, 1, 4'he, 7'h4f, 0));
    tbl.push_back(mk(1, 1, 16'h3333, 4'h0, 1, 4'he, 7'h12, 0));
    tbl.push_back(mk(1, 1, 16'h4444, 4'h0, 1, 4'hd, 7'h06, 0));
    tbl.push_back(mk(1, 1, 16'h5555, 4'h0, 1, 4'hd, 7'h4c, 0));
    tbl.push_back(mk(1, 1, 16'h6666, 4'h0, 1, 4'hd, 7'h24, 0));
    tbl.push_back(mk(1, 1, 16'h7777, 4'h0, 1, 4'hd, 7'h20, 0));
    tbl.push_back(mk(1, 1, 16'h8888, 4'h0, 1, 4'hb, 7'h0f, 0));
    tbl.push_back(mk(1, 1, 16'h9999, 4'h0, 1, 4'hb, 7'h00, 0));
    tbl.push_back(mk(1, 1, 16'haaaa, 4'h0, 1, 4'hb, 7'h04, 0));
    tbl.push_back(mk(1, 1, 16'hbbbb, 4'h0, 1, 4'hb, 7'h7f, 0));
    tbl.push_back(mk(1, 1, 16'hcccc, 4'h0, 1, 4'h7, 7'h7f, 0));
    tbl.push_back(mk(1, 1, 16'hdddd, 4'h0, 1, 4'h7, 7'h7f, 0));
    tbl.push_back(mk(1, 1, 16'heeee, 4'h0, 1, 4'h7, 7'h7f, 0));
    tbl.push_back(mk(1, 1, 16'hffff, 4'h0, 1, 4'h7, 7'h7f, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 1, 4'he, 7'h7f, 0));
    // mid-scan reset clears shadow, prescaler and index
    tbl.push_back(mk(0, 0, 16'h0000, 4'h0, 1, 4'hf, 7'h7f, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 4, 4'he, 7'h7f, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 4'h0, 1, 4'hd, 7'h7f, 0));

    reset_n   = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    blank_in  = '0;

    foreach (tbl[r]) begin
      for (int j = 0; j < tbl[r].n; j++) begin
        reset_n   = tbl[r].rn;
        load      = tbl[r].ld;
        digits_in = tbl[r].dig;
        blank_in  = tbl[r].blk;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("an_out",     {3'b000, an_out},      {3'b000, tbl[r].an});
        check("seg_out",    seg_out,               tbl[r].seg);
        check("frame_done", {6'b000000, frame_done}, {6'b000000, tbl[r].fd});
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
